// File: rtl/pc_pkg.sv
// Shared program-counter definitions: default width, reset value and PC type.
package pc_pkg;

  localparam int unsigned PC_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] PC_RESET_VAL = 16'h0000;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage : pc_pkg

// File: rtl/pc_next.sv
// Next-PC value for the program counter register: aligned load or hold.
// With PC_AUTOINC_EN defined, the hold case becomes a modulo-2^WIDTH increment.
module pc_next
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH      = PC_WIDTH,
  parameter int unsigned ALIGN_BITS = 0
`ifdef PC_AUTOINC_EN
  ,
  parameter logic [WIDTH-1:0] INC_STEP = 1
`endif
) (
  input  logic             enable,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cur_val,
  output logic [WIDTH-1:0] next_val
);

  logic [WIDTH-1:0] align_mask;

  // Mask that clears the ALIGN_BITS low bits; all ones when ALIGN_BITS is 0.
  always_comb begin
    align_mask = '1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < ALIGN_BITS) begin
        align_mask[i] = 1'b0;
      end
    end
  end

  // Load takes priority; otherwise hold (or increment when auto-increment is built in).
  always_comb begin
    next_val = cur_val;
    if (enable) begin
      next_val = load_val & align_mask;
    end else begin
`ifdef PC_AUTOINC_EN
      next_val = cur_val + INC_STEP;
`else
      next_val = cur_val;
`endif
    end
  end

endmodule : pc_next

// File: rtl/program_counter.sv
// Program counter register. Out is driven straight from the PC flop.
// Optional macro PC_AUTOINC_EN: when neither reset nor enable is active,
// the PC advances by INC_STEP each cycle instead of holding.
module program_counter
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL  = PC_RESET_VAL,
  parameter int unsigned      ALIGN_BITS = 0
`ifdef PC_AUTOINC_EN
  ,
  parameter logic [WIDTH-1:0] INC_STEP   = 1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] Out
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

`ifdef PC_AUTOINC_EN
  pc_next #(
    .WIDTH      (WIDTH),
    .ALIGN_BITS (ALIGN_BITS),
    .INC_STEP   (INC_STEP)
  ) u_pc_next (
    .enable   (enable),
    .load_val (In),
    .cur_val  (pc_q),
    .next_val (pc_d)
  );
`else
  pc_next #(
    .WIDTH      (WIDTH),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_pc_next (
    .enable   (enable),
    .load_val (In),
    .cur_val  (pc_q),
    .next_val (pc_d)
  );
`endif

  // PC register; reset overrides any pending load, which is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign Out = pc_q;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter: a default instance and
// an aligned instance (ALIGN_BITS=2, RESET_VAL=16'h0100) share stimulus.
module tb_program_counter;
  import pc_pkg::*;

  logic clk;
  logic rst;
  logic enable;
  pc_t  in_val;
  pc_t  out_a;
  pc_t  out_b;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  program_counter dut_a (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .In     (in_val),
    .Out    (out_a)
  );

  program_counter #(
    .WIDTH      (16),
    .RESET_VAL  (16'h0100),
    .ALIGN_BITS (2)
  ) dut_b (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .In     (in_val),
    .Out    (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input pc_t obs, input pc_t exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic e, input pc_t v);
    rst    = r;
    enable = e;
    in_val = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b0;
    enable    = 1'b0;
    in_val    = '0;
    @(negedge clk);

    // Reset beats load
    step(1'b1, 1'b1, 16'h00FF);
    check("reset_a", out_a, 16'h0000);
    check("reset_b", out_b, 16'h0100);

    // Reset released with enable high: load happens on that edge
    step(1'b0, 1'b1, 16'h00FF);
    check("load_a", out_a, 16'h00FF);
    check("load_b", out_b, 16'h00FC);

    // Output stable through the following cycle
    @(negedge clk);
    check("stable_a", out_a, 16'h00FF);

`ifndef PC_AUTOINC_EN
    step(1'b0, 1'b0, 16'h00FF);
    check("hold0_a", out_a, 16'h00FF);
    step(1'b0, 1'b0, 16'h1234);
    check("hold1_a", out_a, 16'h00FF);
    step(1'b0, 1'b0, 16'hABCD);
    check("hold2_a", out_a, 16'h00FF);
    step(1'b0, 1'b0, 16'h1234);
    check("hold3_a", out_a, 16'h00FF);
    check("hold3_b", out_b, 16'h00FC);
`endif

    // Back-to-back loads
    step(1'b0, 1'b1, 16'h0001);
    check("b2b0_a", out_a, 16'h0001);
    check("b2b0_b", out_b, 16'h0000);
    step(1'b0, 1'b1, 16'hFFFF);
    check("b2b1_a", out_a, 16'hFFFF);
    check("b2b1_b", out_b, 16'hFFFC);
    step(1'b0, 1'b1, 16'h8000);
    check("b2b2_a", out_a, 16'h8000);
    check("b2b2_b", out_b, 16'h8000);

    // Mid-operation reset, then reload
    step(1'b1, 1'b0, 16'h0000);
    check("midrst_a", out_a, 16'h0000);
    check("midrst_b", out_b, 16'h0100);
    step(1'b0, 1'b1, 16'h0042);
    check("reload_a", out_a, 16'h0042);
    check("reload_b", out_b, 16'h0040);

`ifndef PC_AUTOINC_EN
    // Load coincident with reset is dropped, not deferred
    step(1'b1, 1'b1, 16'h5555);
    check("rstload_a", out_a, 16'h0000);
    step(1'b0, 1'b0, 16'h9999);
    check("nodefer_a", out_a, 16'h0000);
    check("nodefer_b", out_b, 16'h0100);
`else
    // Auto-increment with wrap
    step(1'b0, 1'b1, 16'hFFFE);
    check("inc_load_a", out_a, 16'hFFFE);
    check("inc_load_b", out_b, 16'hFFFC);
    step(1'b0, 1'b0, 16'h0000);
    check("inc0_a", out_a, 16'hFFFF);
    check("inc0_b", out_b, 16'hFFFD);
    step(1'b0, 1'b0, 16'h0000);
    check("inc1_a", out_a, 16'h0000);
    check("inc1_b", out_b, 16'hFFFE);
    step(1'b0, 1'b0, 16'h0000);
    check("inc2_a", out_a, 16'h0001);
    check("inc2_b", out_b, 16'hFFFF);
    // Reset still wins over increment
    step(1'b1, 1'b0, 16'h0000);
    check("inc_rst_a", out_a, 16'h0000);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_program_counter
